// File: rtl/nbldpc_gf_pkg.sv
// NB-LDPC GF(q) shared constants and types.
// Used by the message RAM and its clear sequencer.
package nbldpc_gf_pkg;

   localparam int GF_Q      = 8;
   localparam int GF_DW     = 6;
   localparam int MSG_AW    = 3;
   localparam int MSG_DEPTH = 1 << MSG_AW;

   localparam logic [GF_DW-1:0] GF_CLR_VAL = '0;

   typedef enum logic {
      CLR_ST_CLEAR = 1'b0,
      CLR_ST_READY = 1'b1
   } clr_state_e;

endpackage

// File: rtl/gf_msg_ram_clr_fsm.sv
// Clear sequencer for gf_msg_ram: walks every address writing CLR_VAL,
// and muxes the single RAM write port between clear and user writes.
module gf_msg_ram_clr_fsm
   import nbldpc_gf_pkg::*;
#(
   parameter int               DW      = GF_DW,
   parameter int               AW      = MSG_AW,
   parameter int               DEPTH   = 1 << AW,
   parameter logic [DW-1:0]    CLR_VAL = '0
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Clr,
   input  logic          We,
   input  logic [AW-1:0] Waddr,
   input  logic [DW-1:0] Din,
   output logic          Busy,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata
);

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          waddr_ok;

   // State and clear-address registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= CLR_ST_CLEAR;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Next state: Clr always restarts the walk from address 0
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (Clr) begin
         state_d = CLR_ST_CLEAR;
         addr_d  = '0;
      end else if (state_q == CLR_ST_CLEAR) begin
         addr_d = addr_q + 1'b1;
         if (addr_q == LAST_A) begin
            state_d = CLR_ST_READY;
            addr_d  = '0;
         end
      end
   end

   assign Busy     = (state_q == CLR_ST_CLEAR);
   assign waddr_ok = ({1'b0, Waddr} < DEPTH_W);

   // Write-port mux: clear walk owns the port while busy
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = Waddr;
      mem_wdata = Din;
      if (Busy) begin
         mem_we    = 1'b1;
         mem_waddr = addr_q;
         mem_wdata = CLR_VAL;
      end else if (We && !Clr && waddr_ok) begin
         mem_we = 1'b1;
      end
   end

endmodule

// File: rtl/gf_msg_ram.sv
// Simple-dual-port GF(q) message RAM with clear sequencer and read-valid.
// Optional output register stage: GF_MSG_RAM_OUT_REG_EN.
module gf_msg_ram
   import nbldpc_gf_pkg::*;
#(
   parameter int            DW      = GF_DW,
   parameter int            AW      = MSG_AW,
   parameter int            DEPTH   = 1 << AW,
   parameter logic [DW-1:0] CLR_VAL = DW'(GF_CLR_VAL)
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Clr,
   input  logic          We,
   input  logic [AW-1:0] Waddr,
   input  logic [DW-1:0] Din,
   input  logic          Re,
   input  logic [AW-1:0] Raddr,
   output logic [DW-1:0] Dout,
   output logic          Dout_vld,
   output logic          Busy
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   (* ram_style = "block" *)
   logic [DW-1:0] mem [DEPTH];

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [AW-1:0] raddr_q;
   logic          rd_vld_q;
   logic          rd_ok;
   logic [DW-1:0] rd_word;

   gf_msg_ram_clr_fsm #(
      .DW      (DW),
      .AW      (AW),
      .DEPTH   (DEPTH),
      .CLR_VAL (CLR_VAL)
   ) u_clr_fsm (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Clr       (Clr),
      .We        (We),
      .Waddr     (Waddr),
      .Din       (Din),
      .Busy      (Busy),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   // Array write; contents deliberately survive reset
   always_ff @(posedge Clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Read address capture and valid tracking
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         raddr_q  <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_ok;
         if (rd_ok) raddr_q <= Raddr;
      end
   end

   assign rd_ok = Re && !Busy && !Clr;

   // Live array read from the registered address, zero unless valid
   always_comb begin
      rd_word = '0;
      if (rd_vld_q && ({1'b0, raddr_q} < DEPTH_W))
         rd_word = mem[raddr_q];
   end

`ifdef GF_MSG_RAM_OUT_REG_EN
   logic [DW-1:0] dout_q;
   logic          vld_q;

   // Output stage; flushed once the clear sequencer takes over
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else if (Busy) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         dout_q <= rd_word;
         vld_q  <= rd_vld_q;
      end
   end

   assign Dout     = dout_q;
   assign Dout_vld = vld_q;
`else
   assign Dout     = rd_word;
   assign Dout_vld = rd_vld_q;
`endif

endmodule
